// File: rtl/seq_detect_sched.sv
// seq_detect_sched
// Round-robin scheduler in front of one shared serial pattern matcher.
// Two channels offer DATA_W-bit words; the granted word is shifted out
// MSB-first through a PAT_W-bit matcher, and the match count is reported
// together with the id of the channel that supplied the word.
module seq_detect_sched #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              match_pulse,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W);

    // Fill saturates once the history holds a full pattern's worth of
    // preceding bits; only then can the current bit complete a match.
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [DATA_W-1:0]  shift_q,       shift_d;
    logic [PAT_W-2:0]   hist_q,        hist_d;
    logic [FILL_W-1:0]  fill_q,        fill_d;
    logic [BC_W-1:0]    bit_cnt_q,     bit_cnt_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [PAT_W-1:0]   pat_q,         pat_d;
    logic               ovl_q,         ovl_d;
    logic               rr_last_q,     rr_last_d;
    logic [1:0]         gnt_q,         gnt_d;
    logic               match_pulse_q, match_pulse_d;
    logic               done_id_q,     done_id_d;
    logic [CNT_W-1:0]   match_cnt_q,   match_cnt_d;

    logic               cur_bit;
    logic [PAT_W-1:0]   window;
    logic               is_match;
    logic               winner;

    // The bit under test joins the history to form the candidate window;
    // the oldest history bit lines up with the pattern MSB.
    assign cur_bit  = shift_q[DATA_W-1];
    assign window   = {hist_q, cur_bit};
    assign is_match = (fill_q == FILL_MAX) && (window == pat_q);

    // Next-state and datapath update for arbitration, shifting and reporting.
    always_comb begin
        // NOTE: every signal written here gets its default first so that no
        // path through the case statement leaves one unassigned (no latches).
        state_d       = state_q;
        shift_d       = shift_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        bit_cnt_d     = bit_cnt_q;
        cnt_d         = cnt_q;
        pat_d         = pat_q;
        ovl_d         = ovl_q;
        rr_last_d     = rr_last_q;
        gnt_d         = 2'b00;
        match_pulse_d = 1'b0;
        done_id_d     = done_id_q;
        match_cnt_d   = match_cnt_q;
        winner        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // A lone requester wins outright; a tie goes to the
                    // channel that was not served last.
                    winner    = (req == 2'b11) ? ~rr_last_q : req[1];
                    shift_d   = winner ? data1 : data0;
                    pat_d     = cfg_pattern;
                    ovl_d     = cfg_overlap;
                    hist_d    = '0;
                    fill_d    = '0;
                    cnt_d     = '0;
                    bit_cnt_d = BIT_LAST;
                    rr_last_d = winner;
                    gnt_d     = winner ? 2'b10 : 2'b01;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                hist_d  = window[PAT_W-2:0];
                if (is_match) begin
                    match_pulse_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Without overlap the bits that formed this match may
                    // not contribute to the next one, so history is voided.
                    if (!ovl_q) begin
                        fill_d = '0;
                    end
                end else if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end

                if (bit_cnt_q == '0) begin
                    // cnt_d already includes a match on the final bit.
                    match_cnt_d = cnt_d;
                    done_id_d   = rr_last_q;
                    state_d     = REPORT;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            REPORT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any job in flight without reporting it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            hist_q        <= '0;
            fill_q        <= '0;
            bit_cnt_q     <= '0;
            cnt_q         <= '0;
            pat_q         <= '0;
            ovl_q         <= 1'b0;
            rr_last_q     <= 1'b1;
            gnt_q         <= 2'b00;
            match_pulse_q <= 1'b0;
            done_id_q     <= 1'b0;
            match_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values of the previous cycle regardless of statement order.
            state_q       <= state_d;
            shift_q       <= shift_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            bit_cnt_q     <= bit_cnt_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            ovl_q         <= ovl_d;
            rr_last_q     <= rr_last_d;
            gnt_q         <= gnt_d;
            match_pulse_q <= match_pulse_d;
            done_id_q     <= done_id_d;
            match_cnt_q   <= match_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q != IDLE);
    assign match_pulse = match_pulse_q;
    assign done        = (state_q == REPORT);
    assign done_id     = done_id_q;
    assign match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Testbench for seq_detect_sched: directed scenarios followed by random jobs.
// Expected results come from a bit-window reference model and are queued at
// grant time; a monitor collects match pulses and compares on every done.
module tb_seq_detect_sched;

    localparam int DATA_W = 16;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 5;

    typedef struct {
        logic              id;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] mask;   // bit i set: match completed on bit i
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [DATA_W-1:0] data0, data1;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic [1:0]        gnt;
    logic              busy, match_pulse, done, done_id;
    logic [CNT_W-1:0]  match_cnt;

    seq_detect_sched #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .data0       (data0),
        .data1       (data1),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .gnt         (gnt),
        .busy        (busy),
        .match_pulse (match_pulse),
        .done        (done),
        .done_id     (done_id),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic rr_m;
    int   cyc = 0;

    // Inputs as seen by the DUT at the most recent rising edge.
    logic [1:0]        e_req;
    logic [DATA_W-1:0] e_d0, e_d1;
    logic [PAT_W-1:0]  e_pat;
    logic              e_ovl;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        e_req <= req;
        e_d0  <= data0;
        e_d1  <= data1;
        e_pat <= cfg_pattern;
        e_ovl <= cfg_overlap;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: a match ends on bit i when the PAT_W bits ending there equal
    // the pattern and, without overlap, none of them belong to an earlier match.
    function automatic exp_t model(input logic id, input logic [DATA_W-1:0] w,
                                   input logic [PAT_W-1:0] p, input logic ovl);
        exp_t e;
        int   last;
        int   c;
        logic [DATA_W-1:0] sh;
        e.id   = id;
        e.mask = '0;
        last   = -1;
        c      = 0;
        for (int i = PAT_W - 1; i < DATA_W; i++) begin
            sh = w >> (DATA_W - 1 - i);
            if (sh[PAT_W-1:0] == p && i >= last + PAT_W) begin
                c++;
                e.mask[i] = 1'b1;
                if (!ovl) last = i;
            end
        end
        e.cnt = (c > (2 ** CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(c);
        return e;
    endfunction

    // Monitor: track cycles since grant, collect match pulses, score on done.
    logic              in_job = 1'b0;
    int                k = 0;
    logic [DATA_W-1:0] mask_obs;
    int                gnt_count = 0;
    int                done_count = 0;
    logic [CNT_W-1:0]  last_cnt = '0;
    logic              last_id = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_job = 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                in_job   = 1'b1;
                k        = 1;
                mask_obs = '0;
                gnt_count++;
            end else if (in_job) begin
                k++;
            end
            if (in_job && match_pulse && k >= 2 && k <= DATA_W + 1)
                mask_obs[k-2] = 1'b1;
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_id",   32'(done_id),   32'(e.id));
                    check("match_cnt", 32'(match_cnt), 32'(e.cnt));
                    check("pulse_map", 32'(mask_obs),  32'(e.mask));
                    last_cnt = e.cnt;
                    last_id  = e.id;
                end
                in_job = 1'b0;
            end
        end
    end

    // Driver helpers.
    logic [1:0] last_gnt;
    logic       last_w;
    int         gnt_cyc;

    task automatic start(input logic [1:0] r, input logic [DATA_W-1:0] d0,
                         input logic [DATA_W-1:0] d1, input logic [PAT_W-1:0] p,
                         input logic o);
        @(posedge clk);
        #1;
        req         = r;
        data0       = d0;
        data1       = d1;
        cfg_pattern = p;
        cfg_overlap = o;
    endtask

    task automatic grant();
        int   n;
        logic w;
        n = 0;
        @(negedge clk);
        while (gnt == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("gnt_seen", 32'(gnt != 2'b00), 32'd1);
        if (gnt != 2'b00) begin
            w = (e_req == 2'b11) ? ~rr_m : e_req[1];
            check("gnt_winner", 32'(gnt), w ? 32'd2 : 32'd1);
            rr_m     = w;
            last_w   = w;
            last_gnt = gnt;
            gnt_cyc  = cyc;
            sb.push_back(model(w, w ? e_d1 : e_d0, e_pat, e_ovl));
            req[w] = 1'b0;
        end
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("job_ends",  32'(busy),      32'd0);
        check("done_idle", 32'(done),      32'd0);
        check("cnt_held",  32'(match_cnt), 32'(last_cnt));
        check("id_held",   32'(done_id),   32'(last_id));
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [3:0] nib;
        nib = 4'($urandom);
        case ($urandom_range(0, 2))
            0:       return {4{nib}};
            1:       return {8{nib[1:0]}};
            default: return DATA_W'($urandom);
        endcase
    endfunction

    localparam logic [DATA_W-1:0] W_1001 = 16'b1001001001001000;

    initial begin
        int g0;
        int snap;
        logic [1:0]        pend;
        logic [DATA_W-1:0] pd0, pd1;

        reset = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
        cfg_pattern = '0; cfg_overlap = 1'b0; rr_m = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_gnt",   32'(gnt),         32'd0);
        check("rst_pulse", 32'(match_pulse), 32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_cnt",   32'(match_cnt),   32'd0);
        check("rst_id",    32'(done_id),     32'd0);

        // Tie from reset: ch0 first, ch1 one period later.
        start(2'b11, 16'hFFFF, 16'hFFFF, 4'b1111, 1'b1);
        grant();
        check("tie_first", 32'(last_gnt), 32'd1);
        g0 = gnt_cyc;
        finish_job();
        check("ffff_ovl_cnt", 32'(match_cnt), 32'd13);
        grant();
        check("tie_second", 32'(last_gnt), 32'd2);
        check("b2b_period", 32'(gnt_cyc - g0), 32'd18);
        finish_job();
        check("ffff_ovl_cnt1", 32'(match_cnt), 32'd13);
        check("ffff_ovl_id1",  32'(done_id),   32'd1);
        start(2'b11, 16'hFFFF, 16'hFFFF, 4'b1111, 1'b0);
        grant();
        finish_job();
        check("ffff_novl_cnt0", 32'(match_cnt), 32'd4);
        grant();
        finish_job();
        check("ffff_novl_cnt1", 32'(match_cnt), 32'd4);

        // Single channel, overlapping and non-overlapping.
        start(2'b01, W_1001, '0, 4'b1001, 1'b1);
        grant();
        check("ch0_gnt", 32'(last_gnt), 32'd1);
        finish_job();
        check("w1001_ovl_cnt", 32'(match_cnt), 32'd4);
        start(2'b01, W_1001, '0, 4'b1001, 1'b0);
        grant();
        finish_job();
        check("w1001_novl_cnt", 32'(match_cnt), 32'd2);

        // No matches replaces the previous count.
        start(2'b01, 16'h0000, '0, 4'b1001, 1'b1);
        grant();
        finish_job();
        check("zero_cnt", 32'(match_cnt), 32'd0);

        // Config and req changes during SHIFT are ignored.
        start(2'b01, W_1001, '0, 4'b1001, 1'b1);
        grant();
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        cfg_pattern = 4'b0000;
        finish_job();
        check("cfg_ignored_cnt", 32'(match_cnt), 32'd4);
        snap = gnt_count;
        repeat (6) @(negedge clk);
        check("no_regrant", 32'(gnt_count), 32'(snap));

        // Asynchronous reset during S5 abandons the job.
        start(2'b01, W_1001, '0, 4'b1001, 1'b1);
        grant();
        repeat (4) @(negedge clk);
        check("s5_pulse", 32'(match_pulse), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy",  32'(busy),        32'd0);
        check("arst_gnt",   32'(gnt),         32'd0);
        check("arst_pulse", 32'(match_pulse), 32'd0);
        sb.delete();
        rr_m     = 1'b1;
        req      = 2'b00;
        last_cnt = '0;
        last_id  = 1'b0;
        snap     = done_count;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_done", 32'(done_count), 32'(snap));
        start(2'b11, rand_word(), rand_word(), 4'($urandom), 1'($urandom));
        grant();
        check("arst_tie_ch0", 32'(last_gnt), 32'd1);
        finish_job();
        grant();
        finish_job();

        // Random traffic with requests held across other channel's jobs.
        pend = 2'b00;
        pd0  = '0;
        pd1  = '0;
        for (int it = 0; it < 150; it++) begin
            if (!pend[0] && $urandom_range(0, 2) != 0) begin pend[0] = 1'b1; pd0 = rand_word(); end
            if (!pend[1] && $urandom_range(0, 2) != 0) begin pend[1] = 1'b1; pd1 = rand_word(); end
            if (pend == 2'b00) begin
                req = 2'b00;
                repeat (3) begin
                    @(negedge clk);
                    check("idle_no_gnt", 32'(gnt), 32'd0);
                end
            end else begin
                start(pend, pd0, pd1, 4'($urandom), 1'($urandom));
                grant();
                pend[last_w] = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    cfg_pattern = 4'($urandom);
                    cfg_overlap = 1'($urandom);
                end
                finish_job();
            end
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
